tv80_reg_dump: RTL and testbench
================================

# tv80_reg_dump

Debug/save-state readout sequencer for the TV80 register file. On request it stalls the CPU, walks all eight register-file pairs over the spare C read port, and streams the contents as a byte stream with a valid/ready handshake, terminated by a two's-complement checksum byte. It sits beside the register file inside the CPU wrapper and feeds the debug/save-state byte channel.

## Interface
- NUM_PAIRS, 8, register pairs dumped, read at addresses 0..NUM_PAIRS-1; the address width is $clog2(NUM_PAIRS).
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  dump request; sampled only in IDLE.
- abort  in  1  synchronous cancel; effective in any non-IDLE state.
- hold_req  out  1  CPU stall request. It is high in every non-IDLE state, and the wrapper forces register-file CEN low while it is high.
- reg_addr  out  3  drives the register-file C read-port address.
- reg_dh  in  8  C-port high byte. Combinational read of reg_addr.
- reg_dl  in  8  C-port low byte. Combinational read of reg_addr.
- out_data  out  8  stream byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts the byte. A handshake occurs when out_valid and out_ready are both high on a rising edge.
- out_last  out  1  marks the checksum byte (final byte).
- done  out  1  one-cycle pulse on completion.

## Operation
- States:
  - IDLE: start=1 clears addr and sum, then goes to LATCH.
  - LATCH: captures {reg_dh, reg_dl} into a 16-bit snapshot, then goes to SEND_H.
  - SEND_H: sends snap[15:8]; on handshake goes to SEND_L.
  - SEND_L: sends snap[7:0]; on handshake, if addr==NUM_PAIRS-1 goes to SEND_SUM, else increments addr and goes to LATCH.
  - SEND_SUM: sends the checksum with out_last=1; on handshake pulses done and goes to IDLE.
- Byte order: pair 0 H, pair 0 L, … pair 7 H, pair 7 L, checksum. That is 2·NUM_PAIRS+1 bytes (17).
- Checksum:
  - sum is an 8-bit accumulator, modulo 256, of every data byte handshaked.
  - The checksum byte is (~sum + 1) mod 256, so the modulo-256 total of all 17 bytes is 0x00.
- out_valid is high only in SEND_H, SEND_L and SEND_SUM.
- out_data and out_last are held stable while out_valid=1 and out_ready=0.
- out_data is 0x00 when out_valid=0.
- start while not IDLE is ignored. start in the same cycle as the final handshake is ignored; a new dump needs start in IDLE.
- abort has priority over handshakes:
  - Next state is IDLE. out_valid drops the next cycle and done is not pulsed.
  - A byte handshaked in the abort cycle counts as delivered. The sink discards partial dumps that lack out_last.
- Reset values: state IDLE, reg_addr 0, out_valid 0, out_data 0x00, out_last 0, done 0, hold_req 0, sum 0x00, snapshot 0x0000.
- Asynchronous reset mid-dump returns every output to its reset value immediately, with no residual done pulse.

## Timing
- Cycle 0: start sampled in IDLE.
- Cycle 1: LATCH with reg_addr=0 and hold_req=1.
- Cycle 2: first out_valid.
- With out_ready held high, each pair takes 3 cycles (LATCH, H, L). Data bytes occupy cycles 2..24 (valid in 16 of them).
- The checksum is valid in cycle 25. done is high and hold_req low in cycle 26.
- Each cycle out_ready is low stretches the current state by one cycle. There is no added latency otherwise.
- reg_addr changes only on the SEND_L→LATCH transition. The register-file read is combinational, so the capture in LATCH sees data for the current address.

## Structure
- Shared package tv80_dbg_pkg holds:
  - the state enum (IDLE, LATCH, SEND_H, SEND_L, SEND_SUM);
  - the NUM_PAIRS default;
  - the derived dump length constant (2·NUM_PAIRS+1).
- One sub-module, tv80_dbg_csum: an 8-bit accumulator with clear, add-on-strobe and negated output. It is reused by the future save-state loader.
- Everything else, including the FSM, address counter and snapshot, lives in tv80_reg_dump.

## Test plan
- All pairs 0x0000, out_ready=1, start pulse:
  - 16 bytes of 0x00, then checksum 0x00 with out_last=1 at cycle 25;
  - done at cycle 26; hold_req high for cycles 1..25.
- Pair 0 = 0x1234, others 0x0000: stream 0x12, 0x34, fourteen 0x00, then checksum 0xBA.
- Pairs n = {n,n} (0x0000..0x0707), out_ready toggling 1/0 each cycle:
  - bytes in order 00,00,01,01,…,07,07, then checksum 0xC8;
  - out_data stable during every ready-low cycle.
- abort during pair 3 SEND_H:
  - out_valid low and hold_req low the next cycle; no done pulse;
  - a following start yields a complete correct 17-byte dump.
- reset_n asserted mid SEND_L with out_valid high: all outputs at reset values immediately; no done after release.
- start pulsed again during a dump and in the final-handshake cycle: exactly one dump occurs.

Source files
------------

// File: rtl/tv80_dbg_pkg.sv
// Shared definitions for the TV80 debug/save-state blocks: dump FSM states
// and the default register-file dump geometry.
package tv80_dbg_pkg;

  localparam int NUM_PAIRS_DEF = 8;
  localparam int DUMP_LEN      = 2 * NUM_PAIRS_DEF + 1;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SEND_H,
    SEND_L,
    SEND_SUM
  } dump_state_e;

endpackage

// File: rtl/tv80_reg_dump_if.sv
// Byte-stream channel from the dump sequencer to the debug/save-state sink.
interface tv80_reg_dump_if;

  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/tv80_dbg_csum.sv
// 8-bit modulo-256 accumulator with clear and add strobe; o_neg is the
// two's-complement value that brings the running total back to zero.
module tv80_dbg_csum (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_clr,
  input  logic       i_add,
  input  logic [7:0] i_data,
  output logic [7:0] o_neg
);

  logic [7:0] r_sum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sum <= 8'h00;
    end else if (i_clr) begin
      r_sum <= 8'h00;
    end else if (i_add) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_neg = ~r_sum + 8'd1;

endmodule

// File: rtl/tv80_reg_dump.sv
// Register-file dump sequencer: stalls the CPU, walks every register pair over
// the C read port and streams H/L bytes followed by a checksum byte.
module tv80_reg_dump
  import tv80_dbg_pkg::*;
#(
  parameter int NUM_PAIRS = NUM_PAIRS_DEF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         abort,
  output logic                         hold_req,
  output logic [$clog2(NUM_PAIRS)-1:0] reg_addr,
  input  logic [7:0]                   reg_dh,
  input  logic [7:0]                   reg_dl,
  tv80_reg_dump_if.master              strm,
  output logic                         done
);

  localparam int AW = $clog2(NUM_PAIRS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_PAIRS - 1);

  dump_state_e   r_state;
  logic [AW-1:0] r_addr;
  logic [15:0]   r_snap;
  logic          r_valid;
  logic          r_last;
  logic          r_hold;
  logic          r_done;

  logic          w_hs;
  logic          w_add;
  logic          w_clr;
  logic [7:0]    w_csum;
  logic [7:0]    w_data;

  assign w_hs  = r_valid && strm.out_ready;
  assign w_add = w_hs && ((r_state == SEND_H) || (r_state == SEND_L));
  assign w_clr = (r_state == IDLE) && start;

  // The byte on the wire is a pure decode of registered state, so it is
  // inherently stable across ready-low stalls and zero outside SEND_*.
  always_comb begin
    w_data = 8'h00;
    case (r_state)
      SEND_H:   w_data = r_snap[15:8];
      SEND_L:   w_data = r_snap[7:0];
      SEND_SUM: w_data = w_csum;
      default:  w_data = 8'h00;
    endcase
  end

  tv80_dbg_csum u_csum (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_clr),
    .i_add   (w_add),
    .i_data  (w_data),
    .o_neg   (w_csum)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_snap  <= 16'h0000;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_hold  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Abort outranks any handshake in the same cycle; no done pulse.
      if ((r_state != IDLE) && abort) begin
        r_state <= IDLE;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
        r_hold  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_addr  <= '0;
              r_hold  <= 1'b1;
              r_state <= LATCH;
            end
          end
          LATCH: begin
            r_snap  <= {reg_dh, reg_dl};
            r_valid <= 1'b1;
            r_state <= SEND_H;
          end
          SEND_H: begin
            if (w_hs) r_state <= SEND_L;
          end
          SEND_L: begin
            if (w_hs) begin
              if (r_addr == LAST_ADDR) begin
                r_last  <= 1'b1;
                r_state <= SEND_SUM;
              end else begin
                r_addr  <= r_addr + AW'(1);
                r_valid <= 1'b0;
                r_state <= LATCH;
              end
            end
          end
          SEND_SUM: begin
            if (w_hs) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_hold  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign hold_req       = r_hold;
  assign reg_addr       = r_addr;
  assign done           = r_done;
  assign strm.out_data  = w_data;
  assign strm.out_valid = r_valid;
  assign strm.out_last  = r_last;

endmodule

// File: tb/tb_tv80_reg_dump.sv
// Directed bench for tv80_reg_dump: stream order, checksum, timing, stalls,
// abort, asynchronous reset and ignored start requests.
module tb_tv80_reg_dump;
  import tv80_dbg_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic        hold_req;
  logic [2:0]  reg_addr;
  logic [7:0]  reg_dh;
  logic [7:0]  reg_dl;
  logic        done;
  logic [15:0] regs [8];

  int n_cmp;
  int n_err;

  tv80_reg_dump_if strm ();

  tv80_reg_dump dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .abort    (abort),
    .hold_req (hold_req),
    .reg_addr (reg_addr),
    .reg_dh   (reg_dh),
    .reg_dl   (reg_dl),
    .strm     (strm.master),
    .done     (done)
  );

  assign reg_dh = regs[reg_addr][15:8];
  assign reg_dl = regs[reg_addr][7:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one full dump from IDLE and checks every byte against the regs model.
  task automatic dump_check(input string tag, input logic [7:0] exp_csum,
                            input bit toggle, input bit restart);
    logic [7:0] exp_b [DUMP_LEN];
    logic [8:0] prev;
    bit         stall;
    int         idx;
    int         cyc;
    int         fin;
    for (int k = 0; k < 8; k++) begin
      exp_b[2*k]   = regs[k][15:8];
      exp_b[2*k+1] = regs[k][7:0];
    end
    exp_b[DUMP_LEN-1] = exp_csum;
    start = 1'b1;
    strm.out_ready = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_c1_addr"}, reg_addr, 0);
    chk({tag, "_c1_valid"}, strm.out_valid, 0);
    cyc = 1; idx = 0; stall = 1'b0; fin = -1; prev = '0;
    while (idx < DUMP_LEN && cyc < 200) begin
      strm.out_ready = toggle ? cyc[0] : 1'b1;
      start = restart && (cyc == 5 || strm.out_last);
      chk({tag, "_hold"}, hold_req, 1);
      if (!strm.out_valid) chk({tag, "_idle_data"}, strm.out_data, 0);
      if (stall && strm.out_valid)
        chk({tag, "_stable"}, {strm.out_last, strm.out_data}, prev);
      if (strm.out_valid && strm.out_ready) begin
        chk($sformatf("%s_byte%0d", tag, idx), strm.out_data, exp_b[idx]);
        chk($sformatf("%s_last%0d", tag, idx), strm.out_last, (idx == DUMP_LEN-1));
        if (idx == DUMP_LEN-1) fin = cyc;
        idx++;
      end
      stall = strm.out_valid && !strm.out_ready;
      prev  = {strm.out_last, strm.out_data};
      step();
      cyc++;
    end
    start = 1'b0;
    strm.out_ready = 1'b1;
    chk({tag, "_count"}, idx, DUMP_LEN);
    if (!toggle) chk({tag, "_sum_cycle"}, fin, 25);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_hold_end"}, hold_req, 0);
    chk({tag, "_valid_end"}, strm.out_valid, 0);
    step();
    chk({tag, "_done_pulse"}, done, 0);
    $display("dump %s: %0d bytes, checksum 0x%02h", tag, idx, exp_csum);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; strm.out_ready = 1'b0;
    for (int k = 0; k < 8; k++) regs[k] = 16'h0000;
    step(); step();
    chk("rst_hold", hold_req, 0);
    chk("rst_addr", reg_addr, 0);
    chk("rst_valid", strm.out_valid, 0);
    chk("rst_data", strm.out_data, 0);
    chk("rst_last", strm.out_last, 0);
    chk("rst_done", done, 0);
    reset_n = 1'b1;
    step();

    dump_check("zero", 8'h00, 1'b0, 1'b0);

    regs[0] = 16'h1234;
    dump_check("p0_1234_restart", 8'hBA, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      chk("one_dump_hold", hold_req, 0);
      chk("one_dump_valid", strm.out_valid, 0);
      step();
    end

    for (int k = 0; k < 8; k++) regs[k] = {k[7:0], k[7:0]};
    dump_check("nn_toggle", 8'hC8, 1'b1, 1'b0);

    for (int k = 0; k < 8; k++) regs[k] = {8'h10 + k[7:0], 8'h20 + k[7:0]};
    start = 1'b1; strm.out_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("abort_pre_addr", reg_addr, 3);
    chk("abort_pre_valid", strm.out_valid, 1);
    chk("abort_pre_data", strm.out_data, 8'h13);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_valid", strm.out_valid, 0);
    chk("abort_hold", hold_req, 0);
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_done", done, 0);
      step();
    end
    $display("abort at pair 3 SEND_H");
    dump_check("after_abort", 8'h48, 1'b0, 1'b0);

    for (int k = 0; k < 8; k++) regs[k] = {k[7:0], k[7:0]};
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("mid_rst_pre_valid", strm.out_valid, 1);
    chk("mid_rst_pre_data", strm.out_data, 8'h01);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_hold", hold_req, 0);
    chk("mid_rst_addr", reg_addr, 0);
    chk("mid_rst_valid", strm.out_valid, 0);
    chk("mid_rst_data", strm.out_data, 0);
    chk("mid_rst_last", strm.out_last, 0);
    chk("mid_rst_done", done, 0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      chk("post_rst_done", done, 0);
      chk("post_rst_valid", strm.out_valid, 0);
      step();
    end
    $display("reset mid SEND_L recovered");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
